// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter: round-robin arbiter with one-hot rotating ring pointer and bounded grant hold time.
// Optional feature: define ARB_LOCK_EN to add a lock input that suppresses hold-expiry release.
module rr_ring_arbiter #(
    parameter int N = 4,
    parameter int MAX_HOLD = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
`ifdef ARB_LOCK_EN
    input  logic          lock,
`endif
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          busy,
    output logic [N-1:0]  ptr
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [N-1:0] grant_n, ptr_n, arb_ptr;
    logic [IW-1:0] idx_n, win_idx, j;
    logic [CW-1:0] hold_cnt, cnt_n;
    logic found, expire, rel;
    int p;
    assign busy = |grant;
    // pick the first requester at or below the pointer position, wrapping; after a release the
    // pointer used is the rotated one so the outgoing requester ends up at lowest priority
    always_comb begin
        arb_ptr = (state == GRANT) ? {grant[0], grant[N-1:1]} : ptr;
        p = 0;
        found = 1'b0;
        win_idx = '0;
        j = '0;
        for (int i = 0; i < N; i++)
            if (arb_ptr[i]) p = i;
        for (int k = 0; k < N; k++) begin
            j = IW'((p + N - k) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                win_idx = j;
            end
        end
    end
    // release decision for the active grant
    always_comb begin
`ifdef ARB_LOCK_EN
        expire = (hold_cnt == CW'(MAX_HOLD)) && !lock;
`else
        expire = (hold_cnt == CW'(MAX_HOLD));
`endif
        rel = !req[grant_idx] || expire;
    end
    // next-state and next-output logic
    always_comb begin
        state_n = state;
        grant_n = grant;
        idx_n = grant_idx;
        cnt_n = hold_cnt;
        ptr_n = ptr;
        if (state == IDLE) begin
            if (en && found) begin
                state_n = GRANT;
                grant_n = {{(N-1){1'b0}}, 1'b1} << win_idx;
                idx_n = win_idx;
                cnt_n = CW'(1);
            end
        end else if (!rel) begin
            cnt_n = (hold_cnt == CW'(MAX_HOLD)) ? hold_cnt : hold_cnt + CW'(1);
        end else begin
            ptr_n = arb_ptr;
            state_n = (en && found) ? GRANT : IDLE;
            grant_n = (en && found) ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
            idx_n = (en && found) ? win_idx : '0;
            cnt_n = (en && found) ? CW'(1) : '0;
        end
    end
    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            grant_idx <= '0;
            hold_cnt <= '0;
            ptr <= {1'b1, {(N-1){1'b0}}};
        end else begin
            state <= state_n;
            grant <= grant_n;
            grant_idx <= idx_n;
            hold_cnt <= cnt_n;
            ptr <= ptr_n;
        end
    end
endmodule

// File: tb/tb_rr_ring_arbiter.sv
// tb_rr_ring_arbiter: directed test-plan scenarios plus random traffic checked against an integer reference model.
module tb_rr_ring_arbiter;
    localparam int N = 4;
    localparam int MAX_HOLD = 4;
    logic clk = 0, rst = 0, en = 1, lock = 0;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant, ptr;
    logic [1:0] grant_idx;
    logic busy;
    int errors = 0, checks = 0;
    int m_g = -1, m_p = N - 1, m_cnt = 0;
    rr_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .grant(grant), .grant_idx(grant_idx), .busy(busy), .ptr(ptr)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int pick(input int start, input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(start - k + N) % N]) return (start - k + N) % N;
        return -1;
    endfunction
    task automatic model();
        int w;
        bit expired;
        if (rst) begin
            m_g = -1; m_p = N - 1; m_cnt = 0;
        end else if (m_g < 0) begin
            w = pick(m_p, req);
            if (en && w >= 0) begin m_g = w; m_cnt = 1; end
        end else begin
            expired = (m_cnt == MAX_HOLD);
`ifdef ARB_LOCK_EN
            if (lock) expired = 0;
`endif
            if (req[m_g] && !expired) m_cnt = (m_cnt < MAX_HOLD) ? m_cnt + 1 : MAX_HOLD;
            else begin
                m_p = (m_g + N - 1) % N;
                w = pick(m_p, req);
                if (en && w >= 0) begin m_g = w; m_cnt = 1; end
                else begin m_g = -1; m_cnt = 0; end
            end
        end
    endtask
    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("grant", 32'(grant), (m_g < 0) ? 32'd0 : (32'd1 << m_g));
        chk("grant_idx", 32'(grant_idx), (m_g < 0) ? 32'd0 : 32'(m_g));
        chk("busy", 32'(busy), (m_g < 0) ? 32'd0 : 32'd1);
        chk("ptr", 32'(ptr), 32'd1 << m_p);
    endtask
    task automatic do_reset(input logic [N-1:0] r);
        rst = 1; en = 1; lock = 0; req = r;
        step();
        rst = 0;
    endtask
    initial begin
        logic [N-1:0] rot_exp [12];
        rst = 1; req = 4'b1111;
        step(); step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ptr", 32'(ptr), 32'h8);
        rst = 0;
        step();
        chk("rst_release_grant", 32'(grant), 32'h8);
        do_reset(4'b0011);
        for (int i = 0; i < 12; i++) rot_exp[i] = (i >= 4 && i < 8) ? 4'b0001 : 4'b0010;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rotation_grant", 32'(grant), 32'(rot_exp[i]));
            if (i == 4) chk("rotation_ptr_a", 32'(ptr), 32'h1);
            if (i == 8) chk("rotation_ptr_b", 32'(ptr), 32'h8);
        end
        do_reset(4'b0101);
        step(); step();
        chk("early_first", 32'(grant), 32'h4);
        req = 4'b0001;
        step();
        chk("early_grant", 32'(grant), 32'h1);
        chk("early_ptr", 32'(ptr), 32'h2);
        do_reset(4'b0100);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("single_grant", 32'(grant), 32'h4);
            if (i >= 4) chk("single_ptr", 32'(ptr), 32'h2);
        end
        do_reset(4'b1001);
        step();
        chk("en_first", 32'(grant), 32'h8);
        en = 0;
        step(); step(); step();
        chk("en_hold", 32'(grant), 32'h8);
        step();
        chk("en_idle_grant", 32'(grant), 32'h0);
        chk("en_idle_busy", 32'(busy), 32'h0);
        step();
        chk("en_stay_idle", 32'(grant), 32'h0);
        en = 1;
        step();
        chk("en_regrant", 32'(grant), 32'h1);
`ifdef ARB_LOCK_EN
        do_reset(4'b0011);
        lock = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("lock_hold", 32'(grant), 32'h2);
        end
        lock = 0;
        step();
        chk("lock_release", 32'(grant), 32'h1);
`endif
        do_reset(4'b0000);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            en = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 199) == 0);
`ifdef ARB_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`endif
            step();
            chk("onehot", 32'($countones(grant) <= 1), 32'd1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
